// File: rtl/sound_ch2_sequencer.sv
// Channel-2 pulse control: 512 Hz frame sequencer, length counter, volume envelope,
// trigger handling and DAC gating that feed the square-wave generator.
module sound_ch2_sequencer #(
  parameter int CLK_DIV = 65536
) (
  input  logic       I_CLK,
  input  logic       I_RESET_L,
  input  logic       I_SOUND_EN,
  input  logic [7:0] I_NR21,
  input  logic [7:0] I_NR22,
  input  logic [7:0] I_NR24,
  input  logic       I_NR21_WR,
  input  logic       I_NR22_WR,
  input  logic       I_NR24_WR,
  output logic       O_CH2_ON,
  output logic [3:0] O_VOLUME,
  output logic [1:0] O_DUTY,
  output logic [2:0] O_FS_STEP,
  output logic       O_LEN_TICK,
  output logic       O_ENV_TICK
);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic {
    ENV_IDLE = 1'b0,
    ENV_RUN  = 1'b1
  } env_state_t;

  logic [DIV_W-1:0] r_div;
  logic [2:0]       r_fs_step;
  logic             r_len_tick;
  logic             r_env_tick;
  logic             r_ch2_on;
  logic [6:0]       r_len_cnt;
  logic [3:0]       r_vol;
  logic [2:0]       r_env_timer;
  env_state_t       r_env_state;

  logic       w_trigger;
  logic       w_dac_on;
  logic       w_len_en;
  logic [2:0] w_period;
  logic       w_step;
  logic       w_unused_regs;

  assign w_trigger     = I_NR24_WR & I_NR24[7];
  assign w_dac_on      = |I_NR22[7:3];
  assign w_len_en      = I_NR24[6];
  assign w_period      = I_NR22[2:0];
  assign w_step        = (r_div == DIV_LAST);
  // NR22 writes take effect through the live register value; the strobe carries no extra meaning.
  assign w_unused_regs = &{1'b0, I_NR24[5:0], I_NR22_WR};

  // Frame sequencer: each step event emits registered tick pulses for the step just executed.
  always_ff @(posedge I_CLK or negedge I_RESET_L) begin
    if (!I_RESET_L) begin
      r_div      <= '0;
      r_fs_step  <= 3'd0;
      r_len_tick <= 1'b0;
      r_env_tick <= 1'b0;
    end else if (!I_SOUND_EN) begin
      r_div      <= '0;
      r_fs_step  <= 3'd0;
      r_len_tick <= 1'b0;
      r_env_tick <= 1'b0;
    end else begin
      r_len_tick <= 1'b0;
      r_env_tick <= 1'b0;
      if (w_step) begin
        r_div      <= '0;
        r_fs_step  <= r_fs_step + 3'd1;
        r_len_tick <= ~r_fs_step[0];
        r_env_tick <= (r_fs_step == 3'd7);
      end else begin
        r_div <= r_div + DIV_W'(1);
      end
    end
  end

  // Channel state and envelope FSM; trigger outranks register writes, which outrank ticks.
  always_ff @(posedge I_CLK or negedge I_RESET_L) begin
    if (!I_RESET_L) begin
      r_ch2_on    <= 1'b0;
      r_len_cnt   <= 7'd0;
      r_vol       <= 4'd0;
      r_env_timer <= 3'd0;
      r_env_state <= ENV_IDLE;
    end else if (!I_SOUND_EN) begin
      r_ch2_on    <= 1'b0;
      r_len_cnt   <= 7'd0;
      r_vol       <= 4'd0;
      r_env_timer <= 3'd0;
      r_env_state <= ENV_IDLE;
    end else if (w_trigger) begin
      r_ch2_on    <= w_dac_on;
      r_vol       <= I_NR22[7:4];
      r_env_timer <= w_period;
      r_env_state <= ENV_RUN;
      if (r_len_cnt == 7'd0) begin
        r_len_cnt <= 7'd64;
      end
    end else begin
      if (!w_dac_on) begin
        r_ch2_on <= 1'b0;
      end
      if (I_NR21_WR) begin
        r_len_cnt <= 7'd64 - {1'b0, I_NR21[5:0]};
      end else if (r_len_tick && w_len_en && (r_len_cnt != 7'd0)) begin
        r_len_cnt <= r_len_cnt - 7'd1;
        if (r_len_cnt == 7'd1) begin
          r_ch2_on <= 1'b0;
        end
      end
      if (r_env_tick && (r_env_state == ENV_RUN) && (w_period != 3'd0)) begin
        if (r_env_timer <= 3'd1) begin
          r_env_timer <= w_period;
          if (I_NR22[3]) begin
            if (r_vol == 4'd15) r_env_state <= ENV_IDLE;
            else                r_vol       <= r_vol + 4'd1;
          end else begin
            if (r_vol == 4'd0)  r_env_state <= ENV_IDLE;
            else                r_vol       <= r_vol - 4'd1;
          end
        end else begin
          r_env_timer <= r_env_timer - 3'd1;
        end
      end
    end
  end

  assign O_CH2_ON   = r_ch2_on;
  assign O_VOLUME   = r_ch2_on ? r_vol : 4'd0;
  assign O_DUTY     = I_NR21[7:6];
  assign O_FS_STEP  = r_fs_step;
  assign O_LEN_TICK = r_len_tick;
  assign O_ENV_TICK = r_env_tick;

endmodule

// File: tb/tb_sound_ch2_sequencer.sv
// Directed bench for sound_ch2_sequencer with a fast frame sequencer (CLK_DIV=4).
module tb_sound_ch2_sequencer;

  localparam int CLK_DIV = 4;

  logic       clk;
  logic       rst_n;
  logic       sound_en;
  logic [7:0] nr21;
  logic [7:0] nr22;
  logic [7:0] nr24;
  logic       nr21_wr;
  logic       nr22_wr;
  logic       nr24_wr;
  logic       ch2_on;
  logic [3:0] volume;
  logic [1:0] duty;
  logic [2:0] fs_step;
  logic       len_tick;
  logic       env_tick;

  int n_compared;
  int n_mismatch;
  int len_pulses;
  int env_pulses;

  sound_ch2_sequencer #(.CLK_DIV(CLK_DIV)) dut (
    .I_CLK      (clk),
    .I_RESET_L  (rst_n),
    .I_SOUND_EN (sound_en),
    .I_NR21     (nr21),
    .I_NR22     (nr22),
    .I_NR24     (nr24),
    .I_NR21_WR  (nr21_wr),
    .I_NR22_WR  (nr22_wr),
    .I_NR24_WR  (nr24_wr),
    .O_CH2_ON   (ch2_on),
    .O_VOLUME   (volume),
    .O_DUTY     (duty),
    .O_FS_STEP  (fs_step),
    .O_LEN_TICK (len_tick),
    .O_ENV_TICK (env_tick)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatch++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Driver: one-cycle write strobe presented across a rising edge.
  task automatic wr_reg(input int sel, input logic [7:0] val);
    case (sel)
      21: begin nr21 = val; nr21_wr = 1'b1; end
      22: begin nr22 = val; nr22_wr = 1'b1; end
      default: begin nr24 = val; nr24_wr = 1'b1; end
    endcase
    @(negedge clk);
    nr21_wr = 1'b0;
    nr22_wr = 1'b0;
    nr24_wr = 1'b0;
  endtask

  task automatic wait_len_tick(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!len_tick && n < 80);
    check_val(tag, len_tick, 1);
  endtask

  task automatic wait_env_tick(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!env_tick && n < 80);
    check_val(tag, env_tick, 1);
  endtask

  initial begin
    n_compared = 0;
    n_mismatch = 0;
    rst_n    = 1'b0;
    sound_en = 1'b1;
    nr21 = 8'h00; nr22 = 8'h00; nr24 = 8'h00;
    nr21_wr = 1'b0; nr22_wr = 1'b0; nr24_wr = 1'b0;

    repeat (3) @(negedge clk);
    check_val("rst_on",       ch2_on,   0);
    check_val("rst_vol",      volume,   0);
    check_val("rst_fs",       fs_step,  0);
    check_val("rst_len_tick", len_tick, 0);
    check_val("rst_env_tick", env_tick, 0);

    // Release and watch one full 8-step sequence (32 cycles).
    rst_n = 1'b1;
    len_pulses = 0;
    env_pulses = 0;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (len_tick) len_pulses++;
      if (env_tick) env_pulses++;
      if (k == 3) begin
        check_val("pre_first_tick", len_tick, 0);
        check_val("pre_first_fs",   fs_step,  0);
      end
      if (k == 4) begin
        check_val("first_len_tick", len_tick, 1);
        check_val("first_fs",       fs_step,  1);
      end
    end
    check_val("len_pulses_32", len_pulses, 4);
    check_val("env_pulses_32", env_pulses, 1);
    check_val("fs_wrap",       fs_step,    0);

    // Length expiry: 64-62 = 2 length ticks.
    wr_reg(21, 8'h3E);
    wr_reg(22, 8'hF0);
    wr_reg(24, 8'hC0);
    check_val("len_trig_on",  ch2_on, 1);
    check_val("len_trig_vol", volume, 15);
    check_val("len_duty",     duty,   0);
    wait_len_tick("len_tick1_seen");
    @(negedge clk);
    check_val("len_after_tick1", ch2_on, 1);
    wait_len_tick("len_tick2_seen");
    @(negedge clk);
    check_val("len_expired_on",  ch2_on, 0);
    check_val("len_expired_vol", volume, 0);

    // Envelope decrease, period 1.
    wr_reg(22, 8'h21);
    wr_reg(24, 8'h80);
    check_val("dec_vol0", volume, 2);
    check_val("dec_on0",  ch2_on, 1);
    wait_env_tick("dec_tick1_seen");
    @(negedge clk);
    check_val("dec_vol1", volume, 1);
    wait_env_tick("dec_tick2_seen");
    @(negedge clk);
    check_val("dec_vol2", volume, 0);
    check_val("dec_on2",  ch2_on, 1);
    wait_env_tick("dec_tick3_seen");
    @(negedge clk);
    check_val("dec_vol3", volume, 0);

    // Envelope increase and saturation.
    wr_reg(22, 8'hE9);
    wr_reg(24, 8'h80);
    check_val("inc_vol0", volume, 14);
    wait_env_tick("inc_tick1_seen");
    @(negedge clk);
    check_val("inc_vol1", volume, 15);
    wait_env_tick("inc_tick2_seen");
    @(negedge clk);
    check_val("inc_vol2", volume, 15);
    check_val("inc_on2",  ch2_on, 1);

    // DAC gating.
    wr_reg(22, 8'h00);
    check_val("dac_off_clear", ch2_on, 0);
    wr_reg(24, 8'h80);
    check_val("dac_off_trig",  ch2_on, 0);
    wr_reg(22, 8'hF0);
    wr_reg(24, 8'h80);
    check_val("dac_on_trig",   ch2_on, 1);
    check_val("dac_on_vol",    volume, 15);
    wr_reg(22, 8'h07);
    check_val("dac_drop_on",   ch2_on, 0);
    check_val("dac_drop_vol",  volume, 0);

    // Duty passthrough and master enable.
    wr_reg(21, 8'h80);
    check_val("duty_2", duty, 2);
    wr_reg(22, 8'hF0);
    wr_reg(24, 8'h80);
    check_val("master_pre_on", ch2_on, 1);
    sound_en = 1'b0;
    @(negedge clk);
    check_val("master_off_fs",  fs_step, 0);
    check_val("master_off_on",  ch2_on,  0);
    check_val("master_off_vol", volume,  0);
    wr_reg(24, 8'h80);
    check_val("master_off_trig", ch2_on, 0);
    len_pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (len_tick || env_tick) len_pulses++;
    end
    check_val("master_off_ticks", len_pulses, 0);
    check_val("master_off_fs2",   fs_step,    0);

    // Asynchronous reset in mid-play, then restart from step 0.
    sound_en = 1'b1;
    wr_reg(24, 8'h80);
    check_val("mid_on", ch2_on, 1);
    #2 rst_n = 1'b0;
    #1;
    check_val("async_rst_on",  ch2_on, 0);
    check_val("async_rst_vol", volume, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_val("restart_tick", len_tick, 1);
    check_val("restart_fs",   fs_step,  1);
    check_val("restart_on",   ch2_on,   0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule

// File: doc/sound_ch2_sequencer.md
Name: sound_ch2_sequencer

Overview:
Control sequencer for sound channel 2 (pulse channel). Contains the 512 Hz frame sequencer, the length counter, the volume-envelope state machine, trigger handling and DAC gating. Drives enable, volume and duty into the channel-2 square-wave generator. Register values and write strobes come from the NR21/NR22/NR24 io-bus parser registers.

Parameters:
CLK_DIV, 65536, I_CLK cycles per frame-sequencer step (33.554432 MHz / 65536 = 512 Hz); benches use 4.

Ports:
I_CLK  input  1  system clock
I_RESET_L  input  1  reset, asynchronous, active-low
I_SOUND_EN  input  1  master sound enable (NR52 bit 7)
I_NR21  input  8  NR21 value: [7:6] duty, [5:0] length load
I_NR22  input  8  NR22 value: [7:4] initial volume, [3] increase, [2:0] envelope period
I_NR24  input  8  NR24 value: [7] trigger, [6] length enable
I_NR21_WR  input  1  one-cycle pulse, NR21 written this cycle
I_NR22_WR  input  1  one-cycle pulse, NR22 written this cycle
I_NR24_WR  input  1  one-cycle pulse, NR24 written this cycle
O_CH2_ON  output  1  channel active
O_VOLUME  output  4  current envelope volume; 0 whenever O_CH2_ON=0
O_DUTY  output  2  I_NR21[7:6], passed through combinationally
O_FS_STEP  output  3  frame-sequencer step to execute next
O_LEN_TICK  output  1  one-cycle length-clock pulse (256 Hz)
O_ENV_TICK  output  1  one-cycle envelope-clock pulse (64 Hz)

Behaviour:
- Async reset (I_RESET_L=0): all registers 0. O_CH2_ON=0, O_VOLUME=0, O_FS_STEP=0, both ticks 0, len_cnt=0, env_timer=0.
- Divider: div counts 0..CLK_DIV-1 and wraps. Step event = cycle with div==CLK_DIV-1.
- Ticks are registered. In the cycle after a step event, with s = the step just executed:
  - O_LEN_TICK=1 iff s is even.
  - O_ENV_TICK=1 iff s==7.
  - O_FS_STEP=s+1 mod 8.
- I_SOUND_EN=0:
  - div and O_FS_STEP held at 0; no ticks.
  - O_CH2_ON, volume, len_cnt, env_timer cleared.
  - Register writes ignored.
- DAC: dac_on = |I_NR22[7:3]. When dac_on=0, O_CH2_ON clears on the next edge and a trigger does not set it.
- Length counter, 7 bits, range 0..64:
  - NR21 write: len_cnt <= 64 - I_NR21[5:0].
  - Trigger with len_cnt==0: len_cnt <= 64.
  - Length tick with I_NR24[6]=1 and len_cnt!=0: decrement. On the 1->0 transition, O_CH2_ON <= 0 on the same edge.
  - Length tick with I_NR24[6]=0: no change.
- Trigger (I_NR24_WR & I_NR24[7]):
  - O_CH2_ON <= dac_on.
  - volume <= I_NR22[7:4].
  - env_timer <= I_NR22[2:0].
  - env_active <= 1.
- Envelope FSM, states IDLE/RUN. env_active=1 means RUN.
  - Envelope tick in RUN with period P=I_NR22[2:0] != 0: env_timer decrements.
  - When env_timer would reach 0: reload P, then volume +1 if I_NR22[3], else -1.
  - If the step would pass 15 (increase) or 0 (decrease), volume holds and the FSM goes to IDLE.
  - P==0: envelope frozen.
  - IDLE until the next trigger.
- Simultaneous events, priority highest first: reset > I_SOUND_EN=0 > trigger > register write > tick.
  - Trigger plus length tick in the same cycle: load only, no decrement.
  - NR21 write plus length tick in the same cycle: the write value wins.
  - Trigger plus envelope tick in the same cycle: trigger reload wins.
- No latency beyond one register stage. Trigger write at edge N gives O_CH2_ON=1 after edge N.
- Reset mid-playback: outputs drop immediately (asynchronous). After release, operation resumes from step 0.

Test Plan:
- Reset/idle: hold I_RESET_L=0, then release with I_SOUND_EN=1 and CLK_DIV=4 -> all outputs 0; first O_LEN_TICK pulse on cycle 4 after release; O_FS_STEP=1.
- Frame sequencer: run 32 cycles, CLK_DIV=4 -> 4 O_LEN_TICK pulses (steps 0,2,4,6), 1 O_ENV_TICK pulse (step 7), O_FS_STEP back to 0.
- Length expiry: NR21=0x3E, NR22=0xF0, NR24 write 0xC0 -> O_CH2_ON=1, O_VOLUME=15; O_CH2_ON=0 and O_VOLUME=0 right after the 2nd following length tick.
- Envelope decrease: NR22=0x21, NR24 write 0x80 -> volume 2, then 1 after env tick 1, then 0 after tick 2; stays 0; O_CH2_ON stays 1.
- Envelope increase/saturation: NR22=0xE9, trigger -> volume 14, then 15, then holds 15 on later env ticks.
- DAC and master: NR22=0x00 + trigger -> O_CH2_ON stays 0. Then NR22=0xF0, trigger, then write NR22=0x07 -> O_CH2_ON=0 next cycle. Deasserting I_SOUND_EN mid-play -> O_FS_STEP=0, ON=0.
